// File: rtl/divider_16_8_pkg.sv
// Shared definitions for the divider: FSM encoding, default widths and the
// seven-segment glyph table also used by the multiplier top.
package divider_16_8_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Glyphs packed as {a,b,c,d,e,f,g}, active high, index = hex digit.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/divider_16_8_hex_to_seven_seg.sv
// Combinational hex digit to seven-segment decoder, {a,b,c,d,e,f,g} order.
module hex_to_seven_seg
  import divider_16_8_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segs
);

  assign segs = SEG_PATTERNS[digit];

endmodule

// File: rtl/divider_16_8.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SEG_DISPLAY_EN to drive seg_a..seg_g from quotient[3:0] while done.
module divider_16_8
  import divider_16_8_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset_a,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done_flag,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  seg_a,
  output logic                  seg_b,
  output logic                  seg_c,
  output logic                  seg_d,
  output logic                  seg_e,
  output logic                  seg_f,
  output logic                  seg_g
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  div_state_t            state, state_next;
  logic [DIVIDEND_W-1:0] work;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  rem_r;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W-1:0]  diff;
  logic                  q_bit;
  logic                  last_iter;

  // The compare is one bit wider than the divisor; the difference always fits
  // in DIVISOR_W bits because it is strictly less than the divisor.
  assign trial     = {rem_r, work[DIVIDEND_W-1]};
  assign q_bit     = (trial >= {1'b0, dvs});
  assign diff      = trial[DIVISOR_W-1:0] - dvs;
  assign last_iter = (cnt == CNT_W'(1));

  // NOTE: state and datapath registers use non-blocking assignment so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: next state is defaulted first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      done_flag   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      work        <= '0;
      dvs         <= '0;
      rem_r       <= '0;
      cnt         <= '0;
    end else begin
      done_flag <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
            end else begin
              work        <= dividend;
              dvs         <= divisor;
              rem_r       <= '0;
              cnt         <= CNT_W'(DIVIDEND_W);
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          // Dividend bits shift out the top while quotient bits fill from below.
          work  <= {work[DIVIDEND_W-2:0], q_bit};
          rem_r <= q_bit ? diff : trial[DIVISOR_W-1:0];
          cnt   <= cnt - CNT_W'(1);
          if (last_iter) begin
            quotient  <= {work[DIVIDEND_W-2:0], q_bit};
            remainder <= q_bit ? diff : trial[DIVISOR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  logic [6:0] segs;

`ifdef DIV_SEG_DISPLAY_EN
  logic [6:0] segs_raw;

  hex_to_seven_seg u_hex_to_seven_seg (
    .digit (quotient[3:0]),
    .segs  (segs_raw)
  );

  assign segs = done_flag ? segs_raw : 7'd0;
`else
  assign segs = 7'd0;
`endif

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = segs;

endmodule

// File: tb/tb_divider_16_8.sv
// Self-checking bench for divider_16_8: directed cases plus random divides
// against a plain-arithmetic model, with one compare process on every cycle.
module tb_divider_16_8;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        done_flag;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [6:0]  seg_bus;

  int total = 0;
  int bad   = 0;

  logic        model_valid = 1'b0;
  logic [15:0] exp_q;
  logic [7:0]  exp_r;
  logic        exp_z;
  logic [6:0]  last_seg;

  always #5 clk = ~clk;

  assign seg_bus = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

  divider_16_8 dut (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .done_flag   (done_flag),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .seg_a       (seg_a),
    .seg_b       (seg_b),
    .seg_c       (seg_c),
    .seg_d       (seg_d),
    .seg_e       (seg_e),
    .seg_f       (seg_f),
    .seg_g       (seg_g)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Glyph the display must show for a digit, {a,b,c,d,e,f,g}.
  function automatic logic [6:0] exp_seg(input logic [3:0] d);
`ifdef DIV_SEG_DISPLAY_EN
    case (d)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
`else
    return (d == 4'h0) ? 7'd0 : 7'd0;
`endif
  endfunction

  // Single compare process: results while done, dark display otherwise.
  always @(negedge clk) begin
    if (reset_a === 1'b1) begin
      if (done_flag === 1'b1 && model_valid) begin
        check("quotient", 32'(quotient), 32'(exp_q));
        check("remainder", 32'(remainder), 32'(exp_r));
        check("div_by_zero", 32'(div_by_zero), 32'(exp_z));
        check("segments", 32'(seg_bus), 32'(exp_seg(exp_q[3:0])));
      end else if (done_flag === 1'b0) begin
        check("segments_dark", 32'(seg_bus), 32'd0);
      end
    end
  end

  task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs, input int hold);
    int lat;
    int exp_lat;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    if (dvs == 8'd0) begin
      exp_q = 16'hFFFF; exp_r = dvd[7:0]; exp_z = 1'b1; exp_lat = 1;
    end else begin
      exp_q = dvd / 16'(dvs); exp_r = 8'(dvd % 16'(dvs)); exp_z = 1'b0; exp_lat = 17;
    end
    model_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk); #1;
      if (done_flag === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    last_seg = seg_bus;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_done", 32'(done_flag), 32'd1);
    end
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("done_fall", 32'(done_flag), 32'd0);
    model_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done_flag), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_segs", 32'(seg_bus), 32'd0);
    @(negedge clk);
    reset_a = 1'b1;

    run_div(16'd1000, 8'd7, 10);
    check("q_1000_7", 32'(quotient), 32'd142);
    check("r_1000_7", 32'(remainder), 32'd6);
    check("z_1000_7", 32'(div_by_zero), 32'd0);
`ifdef DIV_SEG_DISPLAY_EN
    check("seg_E", 32'(last_seg), 32'h4F);
`else
    check("seg_off", 32'(last_seg), 32'h00);
`endif

    run_div(16'h1234, 8'd0, 0);
    check("q_div0", 32'(quotient), 32'hFFFF);
    check("r_div0", 32'(remainder), 32'h34);
    check("z_div0", 32'(div_by_zero), 32'd1);

    run_div(16'hFFFF, 8'd1, 0);
    check("q_ffff_1", 32'(quotient), 32'hFFFF);
    check("r_ffff_1", 32'(remainder), 32'd0);
    check("z_cleared", 32'(div_by_zero), 32'd0);

    run_div(16'd5, 8'd200, 1);
    check("q_5_200", 32'(quotient), 32'd0);
    check("r_5_200", 32'(remainder), 32'd5);

    // Abort a long divide mid-flight.
    @(negedge clk);
    dividend = 16'd60000;
    divisor  = 8'd13;
    start    = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset_a = 1'b0;
    #1;
    check("abort_done", 32'(done_flag), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    check("abort_segs", 32'(seg_bus), 32'd0);
    @(negedge clk);
    reset_a = 1'b1;
    run_div(16'd21, 8'd7, 0);
    check("q_21_7", 32'(quotient), 32'd3);
    check("r_21_7", 32'(remainder), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] rd;
      logic [7:0]  rv;
      int          sel;
      rd  = 16'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      rv = 8'd0;
      else if (sel == 1) rv = 8'd1;
      else               rv = 8'($urandom_range(1, 255));
      run_div(rd, rv, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
